// File: rtl/midi_pkg.sv
// Shared constants, table entry layout and parser state encoding for the MIDI burst front end.
package midi_pkg;

    localparam int MAX_NOTES = 5;

    localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;
    localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
    localparam logic [7:0] SYSTEM_MIN      = 8'hF0;
    localparam logic [7:0] REALTIME_MIN    = 8'hF8;

    typedef struct packed {
        logic [7:0] status;
        logic [7:0] note;
        logic [7:0] vel;
    } note_entry_t;

    typedef enum logic [1:0] {
        WAIT_STATUS = 2'd0,
        WAIT_NOTE   = 2'd1,
        WAIT_VEL    = 2'd2,
        IGNORE      = 2'd3
    } parser_state_t;

    // Published word layout: {8'h00, status, note, velocity}.
    function automatic logic [31:0] entry_word(input note_entry_t e);
        return {8'h00, e};
    endfunction

endpackage

// File: rtl/midi_burst_if.sv
// Byte-stream input and burst output bundle of midi_burst; slave is the DUT side, master the source/sink side.
// Handshake: midi_valid_in is a one-cycle strobe qualifying midi_byte_in, no backpressure;
// midi_burst_ready_out pulses for one cycle when the other outputs have just been updated.
interface midi_burst_if;
    import midi_pkg::*;

    logic [7:0]    midi_byte_in;
    logic          midi_valid_in;
    logic          midi_burst_ready_out;
    logic [2:0]    on_msg_count_out;
    logic [31:0]   midi_burst_data_out [MAX_NOTES];
    logic          dropped_out;
    parser_state_t parser_state_dbg;

    modport master (
        output midi_byte_in, midi_valid_in,
        input  midi_burst_ready_out, on_msg_count_out, midi_burst_data_out,
        input  dropped_out, parser_state_dbg
    );

    modport slave (
        input  midi_byte_in, midi_valid_in,
        output midi_burst_ready_out, on_msg_count_out, midi_burst_data_out,
        output dropped_out, parser_state_dbg
    );

endinterface

// File: rtl/midi_byte_parser.sv
// MIDI note-message parser with running status; emits one-cycle note messages on the velocity byte.
// Macro MIDI_OMNI_EN: when defined, note messages on every channel are accepted.
module midi_byte_parser
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    byte_i,
    input  logic          valid_i,
    output logic          msg_valid_o,
    output logic          msg_is_on_o,
    output logic [7:0]    msg_status_o,
    output logic [7:0]    msg_note_o,
    output logic [7:0]    msg_vel_o,
    output parser_state_t state_o
);

    parser_state_t state_q, state_d;
    logic [7:0]    status_q, status_d;
    logic [7:0]    note_q, note_d;
    logic          chan_ok;
    logic          is_note_status;

`ifdef MIDI_OMNI_EN
    assign chan_ok = 1'b1;
`else
    assign chan_ok = (byte_i[3:0] == CHANNEL);
`endif

    assign is_note_status = (byte_i[7:4] == STATUS_NOTE_OFF) || (byte_i[7:4] == STATUS_NOTE_ON);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= WAIT_STATUS;
            status_q <= 8'h00;
            note_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            note_q   <= note_d;
        end
    end

    // Real-time bytes fall through untouched; they only matter to the gap counter upstairs.
    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        note_d      = note_q;
        msg_valid_o = 1'b0;
        if (valid_i && (byte_i < REALTIME_MIN)) begin
            if (byte_i >= SYSTEM_MIN) begin
                status_d = 8'h00;
                state_d  = IGNORE;
            end else if (byte_i[7]) begin
                if (is_note_status && chan_ok) begin
                    status_d = byte_i;
                    state_d  = WAIT_NOTE;
                end else begin
                    status_d = 8'h00;
                    state_d  = IGNORE;
                end
            end else begin
                case (state_q)
                    WAIT_NOTE: begin
                        note_d  = byte_i;
                        state_d = WAIT_VEL;
                    end
                    WAIT_VEL: begin
                        msg_valid_o = 1'b1;
                        state_d     = WAIT_NOTE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign msg_status_o = status_q;
    assign msg_note_o   = note_q;
    assign msg_vel_o    = byte_i;
    assign msg_is_on_o  = (status_q[7:4] == STATUS_NOTE_ON) && (byte_i != 8'h00);
    assign state_o      = state_q;

endmodule

// File: rtl/midi_burst.sv
// Sounding-note table with quiet-gap publication: the table is copied to the registered outputs
// once the byte stream has been idle for BURST_GAP_CYCLES after a change. Macro: MIDI_OMNI_EN.
module midi_burst
    import midi_pkg::*;
#(
    parameter int unsigned CHANNEL          = 0,
    parameter int unsigned BURST_GAP_CYCLES = 100000
) (
    input  logic         clk_in,
    input  logic         rst_in,
    midi_burst_if.slave  bus
);

    localparam int             GAP_W     = $clog2(BURST_GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(BURST_GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BURST_GAP_CYCLES - 1);
    localparam logic [2:0]     COUNT_MAX = 3'(MAX_NOTES);

    logic          msg_valid;
    logic          msg_is_on;
    logic [7:0]    msg_status;
    logic [7:0]    msg_note;
    logic [7:0]    msg_vel;
    parser_state_t parser_state;

    note_entry_t      table_q [MAX_NOTES];
    note_entry_t      table_d [MAX_NOTES];
    logic [2:0]       count_q, count_d;
    logic             dirty_q, dirty_d;
    logic             dropped_q, dropped_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [31:0]      out_data_q [MAX_NOTES];
    logic [2:0]       out_count_q;
    logic             ready_q;

    logic             hit;
    logic [2:0]       hit_idx;
    logic             changed;
    logic             drop;
    logic             burst;
    note_entry_t      new_entry;

    midi_byte_parser #(
        .CHANNEL (4'(CHANNEL))
    ) u_parser (
        .clk_i        (clk_in),
        .rst_i        (rst_in),
        .byte_i       (bus.midi_byte_in),
        .valid_i      (bus.midi_valid_in),
        .msg_valid_o  (msg_valid),
        .msg_is_on_o  (msg_is_on),
        .msg_status_o (msg_status),
        .msg_note_o   (msg_note),
        .msg_vel_o    (msg_vel),
        .state_o      (parser_state)
    );

    assign new_entry = '{status: msg_status, note: msg_note, vel: msg_vel};

    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = 0; i < MAX_NOTES; i++) begin
            if (!hit && (3'(i) < count_q) && (table_q[i].note == msg_note)) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    // Entries at or above count are kept zero, so a removal just shifts everything above k down.
    always_comb begin
        table_d = table_q;
        count_d = count_q;
        changed = 1'b0;
        drop    = 1'b0;
        if (msg_valid) begin
            if (msg_is_on) begin
                if (hit) begin
                    if (table_q[hit_idx] != new_entry) begin
                        table_d[hit_idx] = new_entry;
                        changed          = 1'b1;
                    end
                end else if (count_q < COUNT_MAX) begin
                    table_d[count_q] = new_entry;
                    count_d          = count_q + 3'd1;
                    changed          = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else if (hit) begin
                for (int i = 0; i < MAX_NOTES - 1; i++) begin
                    if (3'(i) >= hit_idx) begin
                        table_d[i] = table_q[i+1];
                    end
                end
                table_d[MAX_NOTES-1] = '0;
                count_d              = count_q - 3'd1;
                changed              = 1'b1;
            end
        end
    end

    // A byte arriving on the expiry cycle wins over the burst.
    always_comb begin
        burst     = dirty_q && (gap_q == GAP_LAST) && !bus.midi_valid_in;
        gap_d     = bus.midi_valid_in ? '0 : ((gap_q != GAP_MAX) ? gap_q + 1'b1 : gap_q);
        dirty_d   = changed || (dirty_q && !burst);
        dropped_d = dropped_q || drop;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < MAX_NOTES; i++) begin
                table_q[i]    <= '0;
                out_data_q[i] <= 32'h0;
            end
            count_q     <= 3'd0;
            dirty_q     <= 1'b0;
            dropped_q   <= 1'b0;
            gap_q       <= '0;
            out_count_q <= 3'd0;
            ready_q     <= 1'b0;
        end else begin
            table_q   <= table_d;
            count_q   <= count_d;
            dirty_q   <= dirty_d;
            dropped_q <= dropped_d;
            gap_q     <= gap_d;
            ready_q   <= burst;
            if (burst) begin
                for (int i = 0; i < MAX_NOTES; i++) begin
                    out_data_q[i] <= entry_word(table_q[i]);
                end
                out_count_q <= count_q;
            end
        end
    end

    assign bus.midi_burst_ready_out = ready_q;
    assign bus.on_msg_count_out     = out_count_q;
    assign bus.midi_burst_data_out  = out_data_q;
    assign bus.dropped_out          = dropped_q;
    assign bus.parser_state_dbg     = parser_state;

endmodule
